// File: rtl/write_address_gen_pkg.sv
// Shared constants for the write-side address generator: FSM encoding and
// default resident-window sizes.
package write_address_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int FILT_SIZE_DEF = 16;
  localparam int STRIDE_DEF    = 4;

endpackage

// File: rtl/write_address_gen_occupancy_counter.sv
// Resident-word counter: +1 per written word, -STRIDE per honoured release,
// never dropping below zero.
module write_address_gen_occupancy_counter #(
  parameter int OCC_W  = 7,
  parameter int STRIDE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] occ_o
);

  localparam logic [OCC_W-1:0] STRIDE_V = OCC_W'(STRIDE);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             dec_ok;

  // A release that would underflow is dropped entirely rather than clamped.
  always_comb begin
    dec_ok = dec_i && (occ_q >= STRIDE_V);
    occ_d  = occ_q;
    if (clr_i) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(inc_i) - (dec_ok ? STRIDE_V : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;

endmodule

// File: rtl/write_address_gen.sv
// Write-side address generator for a circular line buffer: accepts a frame of
// words, writes them at wrapping addresses and tracks how many are resident.
module write_address_gen
  import write_address_gen_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 10,
  parameter int FILT_SIZE = FILT_SIZE_DEF,
  parameter int STRIDE    = STRIDE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inner_rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  total_len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              release_i,
  output logic              can_count_o,
  output logic [ADDR_W:0]   occupancy_o,
  output logic              frame_done_o
);

  localparam int OCC_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(2 ** ADDR_W);
  localparam logic [OCC_W-1:0] FILT_V  = OCC_W'(FILT_SIZE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [OCC_W-1:0]  occ;
  logic              accept;
  logic              frame_start;

  assign in_ready_o   = (state_q == ST_WRITE) && (occ < DEPTH_V);
  assign accept       = in_valid_i && in_ready_o;
  assign frame_start  = start_i && (state_q != ST_WRITE);
  assign wr_en_o      = accept;
  assign wr_addr_o    = wptr_q;
  // Data is masked outside a write so the bus is quiet while idle or in reset.
  assign wr_data_o    = accept ? in_data_i : '0;
  assign can_count_o  = (occ >= FILT_V);
  assign occupancy_o  = occ;
  assign frame_done_o = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (inner_rst_i) begin
      state_d = ST_IDLE;
      wptr_d  = '0;
      cnt_d   = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            wptr_d  = '0;
            cnt_d   = '0;
            len_d   = total_len_i;
            state_d = (total_len_i == '0) ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if ((cnt_q + LEN_W'(1)) == len_q) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  write_address_gen_occupancy_counter #(
    .OCC_W  (OCC_W),
    .STRIDE (STRIDE)
  ) u_occupancy_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (inner_rst_i || frame_start),
    .inc_i  (accept),
    .dec_i  (release_i),
    .occ_o  (occ)
  );

endmodule

// File: tb/tb_write_address_gen.sv
// Scoreboard bench for write_address_gen with a frame-level reference model.
module tb_write_address_gen;

  localparam int DEPTH  = 64;
  localparam int FILT   = 16;
  localparam int STRIDE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inner_rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  total_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        release_s = 1'b0;
  logic        can_count;
  logic [6:0]  occupancy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: words remaining in the frame, resident count, next index.
  int m_occ  = 0;
  int m_widx = 0;
  int m_left = 0;
  bit m_busy = 0;
  bit m_done = 0;

  logic [21:0] exp_q[$];

  write_address_gen dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .inner_rst_i  (inner_rst),
    .start_i      (start),
    .total_len_i  (total_len),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .release_i    (release_s),
    .can_count_o  (can_count),
    .occupancy_o  (occupancy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_widx = 0; m_left = 0; m_busy = 0; m_done = 0;
  endtask

  // One clock of stimulus; the expected write is queued when the model says
  // the word will be taken.
  task automatic cycle(input bit v, input bit r, input bit s, input bit ir,
                       input logic [9:0] len);
    bit acc, rel;
    in_valid = v; release_s = r; start = s; inner_rst = ir; total_len = len;
    in_data  = 16'($urandom);
    acc = rst_n && m_busy && (m_occ < DEPTH) && v;
    rel = r && (m_occ >= STRIDE);
    if (acc) exp_q.push_back({6'(m_widx % DEPTH), in_data});
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (ir) model_reset();
    else if (!m_busy && s) begin
      m_occ = 0; m_widx = 0; m_left = int'(len);
      m_busy = (len != 0); m_done = (len == 0);
    end else begin
      if (acc) begin
        m_occ++; m_widx++; m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
      if (rel) m_occ -= STRIDE;
    end
    #1;
  endtask

  // Monitor: per-cycle status against the model, writes against the queue.
  initial begin
    logic [21:0] e;
    bit exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = m_busy && (m_occ < DEPTH);
      chk("in_ready", in_ready, exp_ready);
      chk("wr_en", wr_en, in_valid && exp_ready);
      chk("occupancy", occupancy, m_occ);
      chk("can_count", can_count, m_occ >= FILT);
      chk("frame_done", frame_done, m_done);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e[21:16]);
          chk("wr_data", wr_data, e[15:0]);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_write", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  end

  initial begin
    int n;
    int vp, rp;
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_occupancy", occupancy, 0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // 20-word frame, valid held high
    cycle(0, 0, 1, 0, 20);
    repeat (15) cycle(1, 0, 0, 0, 0);
    chk("len20_cc_before", can_count, 0);
    cycle(1, 0, 0, 0, 0);
    chk("len20_cc_after16", can_count, 1);
    repeat (4) cycle(1, 0, 0, 0, 0);
    chk("len20_done", frame_done, 1);
    chk("len20_occ", occupancy, 20);
    cycle(1, 0, 0, 0, 0);
    chk("len20_stay_done", frame_done, 1);

    // Zero-length frame
    cycle(0, 0, 1, 0, 0);
    chk("len0_done", frame_done, 1);
    chk("len0_occ", occupancy, 0);

    // 80-word frame: fill, stall, single release, refill, wrap
    cycle(0, 0, 1, 0, 80);
    repeat (70) cycle(1, 0, 0, 0, 0);
    chk("full_occ", occupancy, 64);
    chk("full_ready", in_ready, 0);
    cycle(1, 1, 0, 0, 0);
    chk("full_rel_occ", occupancy, 60);
    repeat (4) cycle(1, 0, 0, 0, 0);
    chk("refill_occ", occupancy, 64);
    chk("refill_ready", in_ready, 0);
    n = 0;
    while (!m_done && n < 200) begin cycle(1, n[0], 0, 0, 0); n++; end
    chk("len80_done", frame_done, 1);

    // Accept + release at occupancy 16, then inner_rst mid-frame
    cycle(0, 0, 1, 0, 30);
    n = 0;
    while (m_occ < 16 && n < 100) begin cycle(1, 0, 0, 0, 0); n++; end
    chk("occ16", occupancy, 16);
    cycle(1, 1, 0, 0, 0);
    chk("acc_rel_occ", occupancy, 13);
    chk("acc_rel_cc", can_count, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 30);
    chk("irst_ready", in_ready, 0);
    chk("irst_occ", occupancy, 0);
    chk("irst_wr_en", wr_en, 0);
    chk("irst_cc", can_count, 0);
    chk("irst_done", frame_done, 0);
    cycle(0, 0, 0, 0, 0);

    // Release below STRIDE is ignored; release honoured in DONE
    cycle(0, 0, 1, 0, 2);
    repeat (2) cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("underflow_occ", occupancy, 2);
    cycle(0, 0, 1, 0, 6);
    repeat (6) cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("done_rel_occ", occupancy, 2);
    chk("done_rel_state", frame_done, 1);

    // Randomized frames with stray start pulses and random releases
    for (int f = 0; f < 8; f++) begin
      vp = int'($urandom_range(30, 100));
      rp = int'($urandom_range(10, 60));
      cycle(0, 0, 1, 0, 10'($urandom_range(1, 120)));
      n = 0;
      while (!m_done && n < 3000) begin
        cycle($urandom_range(0, 99) < vp, $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 5, 0, 10'($urandom_range(0, 120)));
        n++;
      end
      chk("rand_frame_finish", frame_done, 1);
      repeat ($urandom_range(0, 3)) cycle(0, $urandom_range(0, 1), 0, 0, 0);
    end

    // Asynchronous reset mid-cycle at occupancy 30
    cycle(0, 0, 1, 0, 40);
    n = 0;
    while (m_occ < 30 && n < 100) begin cycle(1, 0, 0, 0, 0); n++; end
    cycle(0, 0, 0, 0, 0);
    chk("pre_arst_occ", occupancy, 30);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_cc", can_count, 0);
    chk("arst_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
